branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Sits in EX. Resolves conditional branches, JAL and JALR, and compares the actual next PC with the next PC that IF used.
- Produces the one-cycle update bundle (br_update, br, br_JALR, br_address, br_pc) consumed by the branch predictor.
- On mispredict, drives flush and redirect_pc to pc_reg, IF/ID and ID/EX, then squashes wrong-path instructions for a fixed window.
- Keeps saturating branch and mispredict counters for performance debug.

Parameters:
- FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (legal range 1..15).
- COUNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_stall  in  1  EX is held this cycle; nothing is accepted
- ex_is_branch  in  1  B-type conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_funct3  in  3  branch condition
- ex_rs1  in  32  operand 1
- ex_rs2  in  32  operand 2
- ex_imm  in  32  sign-extended immediate
- ex_pc  in  32  PC of the EX instruction
- ex_pred_pc  in  32  next PC that IF fetched after this instruction
- br_update  out  1  one-cycle pulse: a control-flow instruction resolved
- br  out  1  resolved taken
- br_JALR  out  1  resolved instruction was JALR
- br_address  out  32  resolved target
- br_pc  out  32  PC of the resolved instruction
- flush  out  1  squash IF/ID and ID/EX
- redirect_pc  out  32  correct next PC; valid while flush=1
- br_count  out  COUNT_W  accepted control-flow instructions
- mispred_count  out  COUNT_W  accepted mispredicts

Behaviour:
- Accept condition: ex_valid=1, ex_stall=0, state=IDLE, and exactly one of is_branch/is_jal/is_jalr set. Any other case is a no-op: no update, no count. Multiple type flags set is illegal and is treated as a no-op.
- Condition by funct3:
  - 000 BEQ, 001 BNE
  - 100 BLT, 101 BGE (signed)
  - 110 BLTU, 111 BGEU (unsigned)
  - 010 and 011: not taken.
- Targets:
  - branch and JAL: ex_pc + ex_imm
  - JALR: (ex_rs1 + ex_imm) & ~1
  - All sums are 32-bit modulo; wrap-around is ignored.
- Taken: JAL and JALR are always taken. actual_next = taken ? target : ex_pc+4.
- Mispredict: actual_next != ex_pred_pc (full 32-bit compare).
- Latency: all outputs are registered; the cycle after acceptance:
  - br_update=1, br=taken, br_JALR=ex_is_jalr, br_address=target (even when not taken), br_pc=ex_pc.
  - br_update is 0 in every other cycle; br, br_JALR, br_address and br_pc hold their last values.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH on an accepted mispredict. flush=1 and redirect_pc=actual_next starting the next cycle, for exactly FLUSH_CYCLES cycles (down-counter loaded with FLUSH_CYCLES-1).
  - FLUSH: all EX inputs are ignored (wrong path), including a mispredicting branch. Returns to IDLE when the counter reaches 0. redirect_pc is held constant throughout.
  - An accepted instruction can be accepted on the first cycle back in IDLE.
- Counters:
  - br_count increments once per accepted instruction.
  - mispred_count increments once per accepted mispredict.
  - Both saturate at all-ones and never wrap.
- Reset: rst_n=0 asynchronously forces state=IDLE, flush counter=0, and all outputs and counters to 0, including mid-flush. The first accept is possible on the first clk edge after deassertion.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x40, pred_pc=0x104 -> next cycle br_update=1, br=1, br_address=0x140; flush=1 with redirect_pc=0x140 for 2 cycles; mispred_count=1.
- BLT signed, rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken. With pred_pc=pc+4 the BLTU gives no flush, br=0, br_update=1.
- JALR, rs1=0x203, imm=0, pred_pc=0x300 -> br_JALR=1, br_address=0x202, flush with redirect_pc=0x202.
- Mispredict followed by a mispredicting BNE presented during the FLUSH window -> BNE ignored: no br_update, counters unchanged, redirect_pc unchanged.
- ex_stall=1 with a valid branch for 3 cycles, then ex_stall=0 -> exactly one br_update pulse; br_count increments once.
- COUNT_W=4: 20 accepted branches -> br_count=15. rst_n pulsed low mid-flush -> flush=0, counters=0 immediately, before any clk edge.

Source files
------------

// File: rtl/branch_resolver_if.sv
// ============================================================================
// branch_resolver_if : EX-stage control-flow inputs and predictor/flush outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface branch_resolver_if #(
  parameter int COUNT_W = 32
);
  logic               ex_valid;
  logic               ex_stall;
  logic               ex_is_branch;
  logic               ex_is_jal;
  logic               ex_is_jalr;
  logic [2:0]         ex_funct3;
  logic [31:0]        ex_rs1;
  logic [31:0]        ex_rs2;
  logic [31:0]        ex_imm;
  logic [31:0]        ex_pc;
  logic [31:0]        ex_pred_pc;

  logic               br_update;
  logic               br;
  logic               br_JALR;
  logic [31:0]        br_address;
  logic [31:0]        br_pc;
  logic               flush;
  logic [31:0]        redirect_pc;
  logic [COUNT_W-1:0] br_count;
  logic [COUNT_W-1:0] mispred_count;

  modport master (
    output ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_funct3, ex_rs1, ex_rs2, ex_imm, ex_pc, ex_pred_pc,
    input  br_update, br, br_JALR, br_address, br_pc, flush, redirect_pc,
           br_count, mispred_count
  );

  modport slave (
    input  ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr,
           ex_funct3, ex_rs1, ex_rs2, ex_imm, ex_pc, ex_pred_pc,
    output br_update, br, br_JALR, br_address, br_pc, flush, redirect_pc,
           br_count, mispred_count
  );
endinterface

`default_nettype wire

// File: rtl/branch_resolver.sv
// ============================================================================
// branch_resolver : EX-stage branch/JAL/JALR resolution, mispredict flush, stats
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_resolver #(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  branch_resolver_if.slave bus_io
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  redirect_q, redirect_d;

  logic               update_q;
  logic               br_q;
  logic               jalr_q;
  logic [31:0]        addr_q;
  logic [31:0]        pc_q;
  logic [COUNT_W-1:0] br_cnt_q;
  logic [COUNT_W-1:0] mis_cnt_q;

  logic        w_one_type;
  logic        w_accept;
  logic        w_cond;
  logic        w_taken;
  logic        w_mispred;
  logic [31:0] w_pc_sum;
  logic [31:0] w_rs_sum;
  logic [31:0] w_target;
  logic [31:0] w_actual;

  assign w_one_type = $onehot({bus_io.ex_is_branch, bus_io.ex_is_jal, bus_io.ex_is_jalr});
  assign w_accept   = bus_io.ex_valid && !bus_io.ex_stall && (state_q == IDLE) && w_one_type;

  assign w_pc_sum = bus_io.ex_pc + bus_io.ex_imm;
  assign w_rs_sum = bus_io.ex_rs1 + bus_io.ex_imm;
  assign w_target = bus_io.ex_is_jalr ? (w_rs_sum & ~32'd1) : w_pc_sum;

  always_comb begin
    w_cond = 1'b0;
    case (bus_io.ex_funct3)
      3'b000:  w_cond = (bus_io.ex_rs1 == bus_io.ex_rs2);
      3'b001:  w_cond = (bus_io.ex_rs1 != bus_io.ex_rs2);
      3'b100:  w_cond = ($signed(bus_io.ex_rs1) <  $signed(bus_io.ex_rs2));
      3'b101:  w_cond = ($signed(bus_io.ex_rs1) >= $signed(bus_io.ex_rs2));
      3'b110:  w_cond = (bus_io.ex_rs1 <  bus_io.ex_rs2);
      3'b111:  w_cond = (bus_io.ex_rs1 >= bus_io.ex_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken   = bus_io.ex_is_jal || bus_io.ex_is_jalr || (bus_io.ex_is_branch && w_cond);
  assign w_actual  = w_taken ? w_target : (bus_io.ex_pc + 32'd4);
  assign w_mispred = (w_actual != bus_io.ex_pred_pc);

  // While in FLUSH every EX input is wrong-path, so only the counter matters.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = redirect_q;
    case (state_q)
      IDLE: begin
        if (w_accept && w_mispred) begin
          state_d    = FLUSH;
          cnt_d      = c_FLUSH_LOAD;
          redirect_d = w_actual;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      redirect_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_q  <= 1'b0;
      br_q      <= 1'b0;
      jalr_q    <= 1'b0;
      addr_q    <= 32'd0;
      pc_q      <= 32'd0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      update_q <= w_accept;
      if (w_accept) begin
        br_q   <= w_taken;
        jalr_q <= bus_io.ex_is_jalr;
        addr_q <= w_target;
        pc_q   <= bus_io.ex_pc;
        if (br_cnt_q != '1) begin
          br_cnt_q <= br_cnt_q + 1'b1;
        end
        if (w_mispred && (mis_cnt_q != '1)) begin
          mis_cnt_q <= mis_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus_io.br_update     = update_q;
  assign bus_io.br            = br_q;
  assign bus_io.br_JALR       = jalr_q;
  assign bus_io.br_address    = addr_q;
  assign bus_io.br_pc         = pc_q;
  assign bus_io.flush         = (state_q == FLUSH);
  assign bus_io.redirect_pc   = redirect_q;
  assign bus_io.br_count      = br_cnt_q;
  assign bus_io.mispred_count = mis_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolver.sv
// ============================================================================
// tb_branch_resolver : directed table, corner sequences and random vs. model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolver;

  localparam int FLUSH_CYCLES = 2;

  logic clk;
  logic rst_n;

  branch_resolver_if #(.COUNT_W(32)) bus ();
  branch_resolver_if #(.COUNT_W(4))  bus4 ();

  branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .COUNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus_io(bus.slave)
  );
  branch_resolver #(.FLUSH_CYCLES(FLUSH_CYCLES), .COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus_io(bus4.slave)
  );

  assign bus4.ex_valid     = bus.ex_valid;
  assign bus4.ex_stall     = bus.ex_stall;
  assign bus4.ex_is_branch = bus.ex_is_branch;
  assign bus4.ex_is_jal    = bus.ex_is_jal;
  assign bus4.ex_is_jalr   = bus.ex_is_jalr;
  assign bus4.ex_funct3    = bus.ex_funct3;
  assign bus4.ex_rs1       = bus.ex_rs1;
  assign bus4.ex_rs2       = bus.ex_rs2;
  assign bus4.ex_imm       = bus.ex_imm;
  assign bus4.ex_pc        = bus.ex_pc;
  assign bus4.ex_pred_pc   = bus.ex_pred_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid, stall, isb, isj, isr;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, imm, pc, pred;
    logic        e_upd, e_br, e_jalr, e_flush;
    logic [31:0] e_addr, e_redir;
  } row_t;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: what the outputs must show after the current edge
  int          m_left;
  logic [31:0] m_redir, m_addr, m_pc;
  logic        m_upd, m_br, m_jalr;
  longint      m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input logic valid, stall, isb, isj, isr, input logic [2:0] f3,
                              input logic [31:0] rs1, rs2, imm, pc, pred,
                              input logic e_upd, e_br, e_jalr, input logic [31:0] e_addr,
                              input logic e_flush, input logic [31:0] e_redir);
    row_t r;
    r.valid = valid; r.stall = stall; r.isb = isb; r.isj = isj; r.isr = isr;
    r.f3 = f3; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.pc = pc; r.pred = pred;
    r.e_upd = e_upd; r.e_br = e_br; r.e_jalr = e_jalr; r.e_addr = e_addr;
    r.e_flush = e_flush; r.e_redir = e_redir;
    return r;
  endfunction

  function automatic bit cond_ok(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return {1'b0, a} < {1'b0, b};
      3'd7:    return {1'b0, a} >= {1'b0, b};
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_redir = 0; m_addr = 0; m_pc = 0;
    m_upd = 0; m_br = 0; m_jalr = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic model_step(input row_t v);
    logic [31:0] tgt, nxt;
    bit          tk, acc;
    int          nflags;
    nflags = int'(v.isb) + int'(v.isj) + int'(v.isr);
    acc    = v.valid && !v.stall && (m_left == 0) && (nflags == 1);
    if (m_left > 0) m_left--;
    m_upd = 0;
    if (acc) begin
      tgt = v.isr ? ((v.rs1 + v.imm) & 32'hFFFF_FFFE) : (v.pc + v.imm);
      tk  = v.isj || v.isr || (v.isb && cond_ok(v.f3, v.rs1, v.rs2));
      nxt = tk ? tgt : v.pc + 32'd4;
      m_upd = 1; m_br = tk; m_jalr = v.isr; m_addr = tgt; m_pc = v.pc;
      m_bc++;
      if (nxt !== v.pred) begin
        m_mc++;
        m_left  = FLUSH_CYCLES;
        m_redir = nxt;
      end
    end
  endtask

  task automatic drive(input row_t v);
    bus.ex_valid = v.valid; bus.ex_stall = v.stall;
    bus.ex_is_branch = v.isb; bus.ex_is_jal = v.isj; bus.ex_is_jalr = v.isr;
    bus.ex_funct3 = v.f3; bus.ex_rs1 = v.rs1; bus.ex_rs2 = v.rs2;
    bus.ex_imm = v.imm; bus.ex_pc = v.pc; bus.ex_pred_pc = v.pred;
  endtask

  task automatic check_model();
    logic [31:0] sat4;
    sat4 = (m_bc > 15) ? 32'd15 : 32'(m_bc);
    chk("br_update", 32'(bus.br_update), 32'(m_upd));
    chk("br", 32'(bus.br), 32'(m_br));
    chk("br_JALR", 32'(bus.br_JALR), 32'(m_jalr));
    chk("br_address", bus.br_address, m_addr);
    chk("br_pc", bus.br_pc, m_pc);
    chk("flush", 32'(bus.flush), 32'(m_left > 0));
    if (m_left > 0) chk("redirect_pc", bus.redirect_pc, m_redir);
    chk("br_count", bus.br_count, 32'(m_bc));
    chk("mispred_count", bus.mispred_count, 32'(m_mc));
    chk("br_count_w4", 32'(bus4.br_count), sat4);
    chk("mispred_count_w4", 32'(bus4.mispred_count), (m_mc > 15) ? 32'd15 : 32'(m_mc));
  endtask

  task automatic step(input row_t v);
    @(negedge clk);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    check_model();
  endtask

  row_t tbl[16];
  row_t idle;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle = mk(0,0,0,0,0, 3'd0, 0,0,0,0,0, 0,0,0, 0, 0, 0);
    //            v s b j r  f3    rs1           rs2  imm           pc      pred     upd br jr addr      fl redir
    tbl[0]  = mk(1,0,1,0,0, 3'd0, 32'd5,        5,   32'h40,       32'h100, 32'h104, 1,1,0, 32'h140, 1, 32'h140);
    tbl[1]  = mk(1,0,1,0,0, 3'd1, 32'd1,        2,   32'h10,       32'h200, 32'h204, 0,1,0, 32'h140, 1, 32'h140);
    tbl[2]  = mk(1,0,1,0,0, 3'd1, 32'd1,        2,   32'h10,       32'h200, 32'h204, 0,1,0, 32'h140, 0, 32'h140);
    tbl[3]  = mk(1,0,1,0,0, 3'd4, 32'hFFFFFFFF, 1,   32'h20,       32'h300, 32'h320, 1,1,0, 32'h320, 0, 32'h140);
    tbl[4]  = mk(1,0,1,0,0, 3'd6, 32'hFFFFFFFF, 1,   32'h20,       32'h400, 32'h404, 1,0,0, 32'h420, 0, 32'h140);
    tbl[5]  = mk(1,0,0,0,1, 3'd0, 32'h203,      0,   32'h0,        32'h500, 32'h300, 1,1,1, 32'h202, 1, 32'h202);
    tbl[6]  = mk(0,0,0,0,0, 3'd0, 0,            0,   0,            0,       0,       0,1,1, 32'h202, 1, 32'h202);
    tbl[7]  = mk(0,0,0,0,0, 3'd0, 0,            0,   0,            0,       0,       0,1,1, 32'h202, 0, 32'h202);
    tbl[8]  = mk(1,1,1,0,0, 3'd0, 32'd7,        7,   32'h8,        32'h600, 32'h608, 0,1,1, 32'h202, 0, 32'h202);
    tbl[9]  = mk(1,1,1,0,0, 3'd0, 32'd7,        7,   32'h8,        32'h600, 32'h608, 0,1,1, 32'h202, 0, 32'h202);
    tbl[10] = mk(1,1,1,0,0, 3'd0, 32'd7,        7,   32'h8,        32'h600, 32'h608, 0,1,1, 32'h202, 0, 32'h202);
    tbl[11] = mk(1,0,1,0,0, 3'd0, 32'd7,        7,   32'h8,        32'h600, 32'h608, 1,1,0, 32'h608, 0, 32'h202);
    tbl[12] = mk(0,0,0,0,0, 3'd0, 0,            0,   0,            0,       0,       0,1,0, 32'h608, 0, 32'h202);
    tbl[13] = mk(1,0,0,1,0, 3'd0, 32'd0,        0,   32'hFFFFFFF0, 32'h700, 32'h6F0, 1,1,0, 32'h6F0, 0, 32'h202);
    tbl[14] = mk(1,0,1,1,0, 3'd0, 32'd0,        0,   32'h40,       32'h900, 32'h904, 0,1,0, 32'h6F0, 0, 32'h202);
    tbl[15] = mk(1,0,1,0,0, 3'd2, 32'd3,        3,   32'h40,       32'h800, 32'h804, 1,0,0, 32'h840, 0, 32'h202);

    drive(idle);
    rst_n = 1'b0;
    model_reset();
    #23;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i]);
      chk($sformatf("tbl%0d.br_update", i), 32'(bus.br_update), 32'(tbl[i].e_upd));
      chk($sformatf("tbl%0d.br", i), 32'(bus.br), 32'(tbl[i].e_br));
      chk($sformatf("tbl%0d.br_JALR", i), 32'(bus.br_JALR), 32'(tbl[i].e_jalr));
      chk($sformatf("tbl%0d.br_address", i), bus.br_address, tbl[i].e_addr);
      chk($sformatf("tbl%0d.flush", i), 32'(bus.flush), 32'(tbl[i].e_flush));
      if (tbl[i].e_flush) chk($sformatf("tbl%0d.redirect_pc", i), bus.redirect_pc, tbl[i].e_redir);
    end
    chk("tbl.br_count", bus.br_count, 32'd7);
    chk("tbl.mispred_count", bus.mispred_count, 32'd2);

    // async reset in the middle of a flush window
    step(tbl[0]);
    chk("pre_rst.flush", 32'(bus.flush), 32'd1);
    @(negedge clk);
    drive(idle);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.flush", 32'(bus.flush), 32'd0);
    chk("rst.br_count", bus.br_count, 32'd0);
    chk("rst.mispred_count", bus.mispred_count, 32'd0);
    chk("rst.br_count_w4", 32'(bus4.br_count), 32'd0);
    chk("rst.br_update", 32'(bus.br_update), 32'd0);
    chk("rst.br_address", bus.br_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(tbl[3]);
    chk("post_rst.br_update", 32'(bus.br_update), 32'd1);

    // saturation of the narrow counters
    for (int i = 0; i < 20; i++) begin
      step(mk(1,0,1,0,0, 3'd0, 32'd1, 32'd2, 32'h80, 32'h1000 + 32'(i*4), 32'h1004 + 32'(i*4),
              0,0,0, 0, 0, 0));
    end
    chk("sat.br_count_w4", 32'(bus4.br_count), 32'd15);
    chk("sat.br_count", bus.br_count, 32'd21);

    // randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      row_t    v;
      int unsigned sel;
      v = idle;
      v.valid = ($urandom_range(0, 9) != 0);
      v.stall = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      v.isb = (sel <= 5) || (sel == 9);
      v.isj = (sel == 6) || (sel == 9);
      v.isr = (sel == 7);
      v.f3  = 3'($urandom_range(0, 7));
      v.rs1 = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 4)) - 32'd2;
      v.rs2 = ($urandom_range(0, 2) == 0) ? v.rs1 : (($urandom_range(0, 1) != 0) ? $urandom()
                                                   : 32'($urandom_range(0, 4)) - 32'd2);
      v.imm = 32'($signed(13'($urandom())));
      v.pc  = $urandom() & 32'hFFFF_FFFC;
      case ($urandom_range(0, 3))
        0:       v.pred = v.pc + 32'd4;
        1:       v.pred = v.pc + v.imm;
        2:       v.pred = (v.rs1 + v.imm) & 32'hFFFF_FFFE;
        default: v.pred = $urandom();
      endcase
      step(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
